// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline types: NOP bubble, default widths, payload struct.
// Also holds the stage-buffer occupancy state encoding.
package cpu_pipe_pkg;

    localparam int          DEF_INSTR_W = 32;
    localparam int          DEF_PC_W    = 32;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pc;
    } pipe_word_t;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle carrying an instruction word and its PC.
// master drives valid/instr/pc and samples ready; slave does the reverse.
interface pipe_stage_buf_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);

    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;

    modport master (output valid, instr, pc, input ready);
    modport slave  (input valid, instr, pc, output ready);

endinterface

// File: rtl/pipe_skid_slot.sv
// Single payload register with load enable and synchronous clear.
// Ports: clk, reset_n (async low), clr (wins over ld), ld, d, q.
module pipe_skid_slot #(
    parameter int           W       = 64,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLR_VAL;
        end else if (ld) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= CLR_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready, flush and optional skid.
// Ports: clk, reset_n, flush, up (slave), dn (master), occupancy[1:0].
module pipe_stage_buf #(
    parameter int                 INSTR_W   = cpu_pipe_pkg::DEF_INSTR_W,
    parameter int                 PC_W      = cpu_pipe_pkg::DEF_PC_W,
    parameter int                 SKID      = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pipe_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    pipe_stage_buf_if.slave     up,
    pipe_stage_buf_if.master    dn,
    output logic [1:0]          occupancy
);

    import cpu_pipe_pkg::*;

    localparam int           W        = INSTR_W + PC_W;
    // Main slot content whenever nothing valid is held.
    localparam logic [W-1:0] CLR_WORD = {NOP_INSTR, {PC_W{1'b0}}};

    pipe_state_e  state_d;
    pipe_state_e  state_q;
    logic         dn_valid_d;
    logic         dn_valid_q;
    logic         up_ready_d;
    logic         up_ready_q;

    logic         up_ready;
    logic         up_fire;
    logic         dn_fire;
    logic         main_ld;
    logic         main_clr;
    logic         main_from_skid;
    logic         skid_ld;
    logic [W-1:0] up_word;
    logic [W-1:0] main_in;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    assign up_word = {up.instr, up.pc};
    assign up_fire = up.valid & up_ready;
    assign dn_fire = dn_valid_q & dn.ready;

    // Without a skid entry, accept only when the single slot drains now.
    assign up_ready = (SKID != 0) ? up_ready_q
                                  : (!dn_valid_q | dn.ready);

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (up_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (up_fire && dn_fire) begin
                        main_ld = 1'b1;
                    end else if (up_fire) begin
                        // Only reachable with a skid entry.
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (dn_fire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (dn_fire) begin
                        state_d        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                end
            endcase
        end
        dn_valid_d = (state_d != ST_EMPTY);
        up_ready_d = (state_d != ST_TWO);
        main_in    = main_from_skid ? skid_q : up_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            dn_valid_q <= 1'b0;
            up_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            dn_valid_q <= dn_valid_d;
            up_ready_q <= up_ready_d;
        end
    end

    pipe_skid_slot #(
        .W       (W),
        .CLR_VAL (CLR_WORD)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (main_clr),
        .ld      (main_ld),
        .d       (main_in),
        .q       (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_skid_slot #(
            .W       (W),
            .CLR_VAL (CLR_WORD)
        ) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (flush),
            .ld      (skid_ld),
            .d       (up_word),
            .q       (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = CLR_WORD;
    end

    assign up.ready   = up_ready;
    assign dn.valid   = dn_valid_q;
    assign dn.instr   = main_q[W-1:PC_W];
    assign dn.pc      = main_q[PC_W-1:0];
    assign occupancy  = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf, SKID=1 (dut_a) and SKID=0 (dut_b).
// Both DUTs share stimulus; each has its own scoreboard queue.
module tb_pipe_stage_buf;

    import cpu_pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        up_valid = 1'b0;
    logic [31:0] up_instr = '0;
    logic [31:0] up_pc = '0;
    logic        dn_ready = 1'b0;
    logic [1:0]  occ_a;
    logic [1:0]  occ_b;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_word_t sb_a[$];
    pipe_word_t sb_b[$];
    logic       acc_a;
    logic       acc_b;
    logic       hold_a = 1'b0;
    pipe_word_t held_a;

    pipe_stage_buf_if #(.INSTR_W(32), .PC_W(32)) a_up ();
    pipe_stage_buf_if #(.INSTR_W(32), .PC_W(32)) a_dn ();
    pipe_stage_buf_if #(.INSTR_W(32), .PC_W(32)) b_up ();
    pipe_stage_buf_if #(.INSTR_W(32), .PC_W(32)) b_dn ();

    assign a_up.valid = up_valid;
    assign a_up.instr = up_instr;
    assign a_up.pc    = up_pc;
    assign a_dn.ready = dn_ready;
    assign b_up.valid = up_valid;
    assign b_up.instr = up_instr;
    assign b_up.pc    = up_pc;
    assign b_dn.ready = dn_ready;

    pipe_stage_buf #(.INSTR_W(32), .PC_W(32), .SKID(1), .NOP_INSTR(NOP)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .up        (a_up),
        .dn        (a_dn),
        .occupancy (occ_a)
    );

    pipe_stage_buf #(.INSTR_W(32), .PC_W(32), .SKID(0), .NOP_INSTR(NOP)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .up        (b_up),
        .dn        (b_dn),
        .occupancy (occ_b)
    );

    always #5 clk = ~clk;

    // Sample at negedge (inputs driven at posedge+1), then advance one edge.
    task automatic step();
        pipe_word_t exp;
        @(negedge clk);
        acc_a = a_up.valid && a_up.ready;
        acc_b = b_up.valid && b_up.ready;
        if (a_dn.valid && dn_ready) begin
            n_tests++;
            if (sb_a.size() == 0) begin
                n_fail++;
                $display("FAIL sb_a_extra got %h@%h expected none",
                         a_dn.instr, a_dn.pc);
            end else begin
                exp = sb_a.pop_front();
                if (a_dn.instr !== exp.instr || a_dn.pc !== exp.pc) begin
                    n_fail++;
                    $display("FAIL sb_a_order got %h@%h expected %h@%h",
                             a_dn.instr, a_dn.pc, exp.instr, exp.pc);
                end
            end
        end
        if (b_dn.valid && dn_ready) begin
            n_tests++;
            if (sb_b.size() == 0) begin
                n_fail++;
                $display("FAIL sb_b_extra got %h@%h expected none",
                         b_dn.instr, b_dn.pc);
            end else begin
                exp = sb_b.pop_front();
                if (b_dn.instr !== exp.instr || b_dn.pc !== exp.pc) begin
                    n_fail++;
                    $display("FAIL sb_b_order got %h@%h expected %h@%h",
                             b_dn.instr, b_dn.pc, exp.instr, exp.pc);
                end
            end
        end
        if (hold_a) begin
            n_tests++;
            if (a_dn.instr !== held_a.instr || a_dn.pc !== held_a.pc) begin
                n_fail++;
                $display("FAIL hold_a got %h@%h expected %h@%h",
                         a_dn.instr, a_dn.pc, held_a.instr, held_a.pc);
            end
        end
        if (!a_dn.valid) begin
            n_tests++;
            if (a_dn.instr !== NOP || a_dn.pc !== 32'h0) begin
                n_fail++;
                $display("FAIL bubble_a got %h@%h expected %h@0",
                         a_dn.instr, a_dn.pc, NOP);
            end
        end
        if (!b_dn.valid) begin
            n_tests++;
            if (b_dn.instr !== NOP || b_dn.pc !== 32'h0) begin
                n_fail++;
                $display("FAIL bubble_b got %h@%h expected %h@0",
                         b_dn.instr, b_dn.pc, NOP);
            end
        end
        hold_a = a_dn.valid && !dn_ready && !flush;
        held_a = '{instr: a_dn.instr, pc: a_dn.pc};
        if (flush) begin
            sb_a.delete();
            sb_b.delete();
        end else begin
            if (acc_a) sb_a.push_back('{instr: up_instr, pc: up_pc});
            if (acc_b) sb_b.push_back('{instr: up_instr, pc: up_pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        up_valid = 1'b0;
        flush    = 1'b0;
        dn_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n_tests++;
        if (sb_a.size() != 0 || sb_b.size() != 0 || occ_a !== 2'd0) begin
            n_fail++;
            $display("FAIL drain left a=%0d b=%0d occ_a=%0d expected 0/0/0",
                     sb_a.size(), sb_b.size(), occ_a);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (a_dn.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid_a got %b expected 0", a_dn.valid);
        end
        n_tests++;
        if (a_dn.instr !== NOP) begin
            n_fail++;
            $display("FAIL rst_instr_a got %h expected %h", a_dn.instr, NOP);
        end
        n_tests++;
        if (a_dn.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_pc_a got %h expected 0", a_dn.pc);
        end
        n_tests++;
        if (a_up.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready_a got %b expected 1", a_up.ready);
        end
        n_tests++;
        if (occ_a !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_occ_a got %0d expected 0", occ_a);
        end
        n_tests++;
        if (b_dn.valid !== 1'b0 || b_up.ready !== 1'b1 || occ_b !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_b got v=%b r=%b o=%0d expected 0/1/0",
                     b_dn.valid, b_up.ready, occ_b);
        end
    endtask

    task automatic test_stream();
        dn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_instr = 32'hA + i;
            up_pc    = 32'(4 * i);
            step();
            n_tests++;
            if (a_dn.valid !== 1'b1 || a_dn.instr !== 32'hA + i ||
                a_dn.pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_out%0d got %b %h@%h expected 1 %h@%h",
                         i, a_dn.valid, a_dn.instr, a_dn.pc, 32'hA + i, 4 * i);
            end
            n_tests++;
            if (occ_a !== 2'd1 || a_up.ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_occ%0d got occ=%0d rdy=%b expected 1/1",
                         i, occ_a, a_up.ready);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_instr = 32'h11;
        up_pc    = 32'h100;
        step();
        up_instr = 32'h22;
        up_pc    = 32'h104;
        step();
        n_tests++;
        if (occ_a !== 2'd2 || a_up.ready !== 1'b0 || a_dn.instr !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_full got occ=%0d rdy=%b instr=%h expected 2/0/11",
                     occ_a, a_up.ready, a_dn.instr);
        end
        up_instr = 32'h33;
        up_pc    = 32'h108;
        step();
        step();
        n_tests++;
        if (occ_a !== 2'd2 || a_dn.instr !== 32'h11 || a_dn.pc !== 32'h100) begin
            n_fail++;
            $display("FAIL bp_hold got occ=%0d %h@%h expected 2 11@100",
                     occ_a, a_dn.instr, a_dn.pc);
        end
        dn_ready = 1'b1;
        acc_a = 1'b0;
        for (int i = 0; i < 10 && !acc_a; i++) step();
        n_tests++;
        if (!acc_a) begin
            n_fail++;
            $display("FAIL bp_accept got none expected 33 accepted");
        end
        drain();
    endtask

    task automatic test_flush();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_instr = 32'h55;
        up_pc    = 32'h200;
        step();
        up_instr = 32'h66;
        up_pc    = 32'h204;
        step();
        n_tests++;
        if (occ_a !== 2'd2) begin
            n_fail++;
            $display("FAIL fl_pre got occ=%0d expected 2", occ_a);
        end
        flush    = 1'b1;
        up_instr = 32'h44;
        up_pc    = 32'h208;
        step();
        flush    = 1'b0;
        up_valid = 1'b0;
        n_tests++;
        if (a_dn.valid !== 1'b0 || a_dn.instr !== NOP || a_dn.pc !== 32'h0 ||
            occ_a !== 2'd0 || a_up.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_two got v=%b %h@%h occ=%0d rdy=%b expected 0 NOP@0 0 1",
                     a_dn.valid, a_dn.instr, a_dn.pc, occ_a, a_up.ready);
        end
        up_valid = 1'b1;
        up_instr = 32'h77;
        up_pc    = 32'h20c;
        step();
        flush    = 1'b1;
        dn_ready = 1'b1;
        up_instr = 32'h45;
        up_pc    = 32'h210;
        step();
        flush    = 1'b0;
        up_valid = 1'b0;
        n_tests++;
        if (a_dn.valid !== 1'b0 || occ_a !== 2'd0 ||
            b_dn.valid !== 1'b0 || occ_b !== 2'd0) begin
            n_fail++;
            $display("FAIL fl_one got va=%b oa=%0d vb=%b ob=%0d expected 0/0/0/0",
                     a_dn.valid, occ_a, b_dn.valid, occ_b);
        end
        drain();
    endtask

    task automatic test_skid0();
        logic [2:0]  pat;
        logic [31:0] nxt;
        pat = 3'b101;
        nxt = 32'h70;
        up_valid = 1'b1;
        up_instr = nxt;
        up_pc    = 32'h400;
        dn_ready = 1'b1;
        step();
        if (acc_b) nxt = nxt + 1;
        for (int k = 0; k < 9; k++) begin
            up_instr = nxt;
            up_pc    = 32'h400 + 32'(nxt - 32'h70) * 4;
            dn_ready = pat[k % 3];
            #1;
            n_tests++;
            if (b_dn.valid !== 1'b1 || b_up.ready !== dn_ready) begin
                n_fail++;
                $display("FAIL s0_ready%0d got v=%b rdy=%b expected 1/%b",
                         k, b_dn.valid, b_up.ready, dn_ready);
            end
            n_tests++;
            if (occ_b > 2'd1) begin
                n_fail++;
                $display("FAIL s0_occ%0d got %0d expected <=1", k, occ_b);
            end
            step();
            if (acc_b) nxt = nxt + 1;
        end
        drain();
    endtask

    task automatic test_async_reset();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_instr = 32'h81;
        up_pc    = 32'h500;
        step();
        up_instr = 32'h82;
        up_pc    = 32'h504;
        step();
        n_tests++;
        if (occ_a !== 2'd2) begin
            n_fail++;
            $display("FAIL ar_pre got occ=%0d expected 2", occ_a);
        end
        up_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (a_dn.valid !== 1'b0 || a_dn.instr !== NOP || a_dn.pc !== 32'h0 ||
            occ_a !== 2'd0 || a_up.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_async got v=%b %h@%h occ=%0d rdy=%b expected 0 NOP@0 0 1",
                     a_dn.valid, a_dn.instr, a_dn.pc, occ_a, a_up.ready);
        end
        sb_a.delete();
        sb_b.delete();
        hold_a = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        up_valid = 1'b1;
        up_instr = 32'h99;
        up_pc    = 32'h300;
        step();
        up_valid = 1'b0;
        n_tests++;
        if (a_dn.valid !== 1'b1 || a_dn.instr !== 32'h99 || a_dn.pc !== 32'h300) begin
            n_fail++;
            $display("FAIL ar_first got v=%b %h@%h expected 1 99@300",
                     a_dn.valid, a_dn.instr, a_dn.pc);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
